// File: rtl/shift_input_conditioner.sv
// Synchronises and debounces lever and brake inputs, then issues single-cycle, rate-limited shift pulses.
// Latency: raw press to pulse is DEBOUNCE_CYCLES+2 cycles. No backpressure; presses in holdoff are dropped.
// Optional auto-repeat of a held lever is enabled with the AUTO_REPEAT_EN macro.
module shift_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250,
    parameter int HOLDOFF_CYCLES  = 1250,
    parameter int REPEAT_CYCLES   = 12500
) (
    input  logic clk,
    input  logic reset,
    input  logic shift_up_raw,
    input  logic shift_down_raw,
    input  logic brake_raw,
    output logic shift_up,
    output logic shift_down,
    output logic brake,
    output logic busy
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOW = $clog2(HOLDOFF_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || HOLDOFF_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("shift_input_conditioner: cycle parameters must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;

    // Channel index: 0 = up lever, 1 = down lever, 2 = brake
    logic [2:0]     raw;
    logic [2:0]     s1;
    logic [2:0]     s2;
    logic [2:0]     db;
    logic [1:0]     db_d;
    logic [DBW-1:0] cnt [3];

    state_t         state;
    logic [HOW-1:0] hold_cnt;

    logic rise_up;
    logic rise_dn;
    logic press_up;
    logic press_dn;
    logic fire_up;
    logic fire_dn;

    assign raw = {brake_raw, shift_down_raw, shift_up_raw};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_d <= db[1:0];
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign brake   = db[2];
    assign rise_up = db[0] & ~db_d[0];
    assign rise_dn = db[1] & ~db_d[1];

    // Simultaneous edges are ambiguous and dropped; braking blocks up-shifts only.
    assign press_up = rise_up & ~rise_dn & ~db[2];
    assign press_dn = rise_dn & ~rise_up;

`ifdef AUTO_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_CYCLES + 1);

    logic           rep_act;
    logic           rep_dn;
    logic [RPW-1:0] rep_cnt;
    logic           rep_hold;
    logic           rep_due;

    // Repeat only while the same lever alone stays debounced high.
    assign rep_hold = rep_dn ? (db[1] & ~db[0]) : (db[0] & ~db[1]);
    assign rep_due  = rep_act & rep_hold & (rep_cnt == RPW'(REPEAT_CYCLES - 1));
    assign fire_up  = press_up | (rep_due & ~rep_dn & ~db[2] & ~rise_dn);
    assign fire_dn  = press_dn | (rep_due &  rep_dn & ~rise_up);

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_act <= 1'b0;
            rep_dn  <= 1'b0;
            rep_cnt <= '0;
        end else if (state == IDLE && (fire_up || fire_dn)) begin
            rep_act <= 1'b1;
            rep_dn  <= fire_dn;
            rep_cnt <= '0;
        end else if (rep_act && rep_hold) begin
            if (rep_cnt != RPW'(REPEAT_CYCLES - 1)) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end else begin
            rep_act <= 1'b0;
            rep_cnt <= '0;
        end
    end
`else
    assign fire_up = press_up;
    assign fire_dn = press_dn;
`endif

    // busy is driven from the next-state decision so it rises with the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            shift_up   <= 1'b0;
            shift_down <= 1'b0;
            busy       <= 1'b0;
        end else begin
            shift_up   <= 1'b0;
            shift_down <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire_up) begin
                        state    <= PULSE;
                        shift_up <= 1'b1;
                        busy     <= 1'b1;
                    end else if (fire_dn) begin
                        state      <= PULSE;
                        shift_down <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                PULSE: begin
                    state    <= HOLDOFF;
                    hold_cnt <= '0;
                    busy     <= 1'b1;
                end
                HOLDOFF: begin
                    if (hold_cnt == HOW'(HOLDOFF_CYCLES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_input_conditioner.sv
// Bench for shift_input_conditioner: expected pulses and busy windows are queued as stimulus is driven.
module tb_shift_input_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int REP  = 20;
    localparam int LAT  = DEB + 3;  // input changed after edge e -> pulse at edge e+LAT

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic shift_up_raw = 1'b0;
    logic shift_down_raw = 1'b0;
    logic brake_raw = 1'b0;
    logic shift_up;
    logic shift_down;
    logic brake;
    logic busy;

    shift_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLDOFF_CYCLES (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .shift_up_raw  (shift_up_raw),
        .shift_down_raw(shift_down_raw),
        .brake_raw     (brake_raw),
        .shift_up      (shift_up),
        .shift_down    (shift_down),
        .brake         (brake),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    int n_cmp  = 0;
    int n_err  = 0;
    int exp_edge_q[$];
    int exp_dn_q[$];
    int win_lo[$];
    int win_hi[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d, want %0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic expect_pulse(input int e, input int dn);
        exp_edge_q.push_back(e);
        exp_dn_q.push_back(dn);
        win_lo.push_back(e);
        win_hi.push_back(e + HOLD);
    endtask

    function automatic int busy_exp(input int e);
        for (int i = 0; i < win_lo.size(); i++) begin
            if (e >= win_lo[i] && e <= win_hi[i]) return 1;
        end
        return 0;
    endfunction

    task automatic to_edge(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: counts edges and checks outputs 2 time units after each edge.
    initial begin
        int e_edge;
        int e_dn;
        forever begin
            @(posedge clk);
            edge_n++;
            #2;
            chk("busy", int'(busy), busy_exp(edge_n));
            if (shift_up && shift_down) chk("both_pulses", 1, 0);
            if (shift_up || shift_down) begin
                if (exp_edge_q.size() == 0) begin
                    chk("spurious_pulse_edge", edge_n, -1);
                end else begin
                    e_edge = exp_edge_q.pop_front();
                    e_dn   = exp_dn_q.pop_front();
                    chk("pulse_edge", edge_n, e_edge);
                    chk("pulse_is_down", int'(shift_down), e_dn);
                end
            end
        end
    end

    initial begin
        // Reset state
        to_edge(2);
        chk("rst_up", int'(shift_up), 0);
        chk("rst_dn", int'(shift_down), 0);
        chk("rst_brake", int'(brake), 0);
        chk("rst_busy", int'(busy), 0);
        to_edge(3);
        reset = 1'b0;

        // Single up press
        to_edge(9);
        shift_up_raw = 1'b1;
        expect_pulse(9 + LAT, 0);
        to_edge(25);
        shift_up_raw = 1'b0;

        // Glitches of 1, 2 and 3 cycles never pass the debouncer
        to_edge(50); shift_up_raw = 1'b1;
        to_edge(51); shift_up_raw = 1'b0;
        to_edge(56); shift_up_raw = 1'b1;
        to_edge(58); shift_up_raw = 1'b0;
        to_edge(63); shift_up_raw = 1'b1;
        to_edge(66); shift_up_raw = 1'b0;

        // Down edge inside holdoff is dropped; a later press fires
        to_edge(80);
        shift_up_raw = 1'b1;
        expect_pulse(80 + LAT, 0);
        to_edge(83);
        shift_down_raw = 1'b1;
        to_edge(95);
        shift_up_raw   = 1'b0;
        shift_down_raw = 1'b0;
        to_edge(115);
        shift_down_raw = 1'b1;
        expect_pulse(115 + LAT, 1);
        to_edge(125);
        shift_down_raw = 1'b0;

        // Brake blocks up-shift, not down-shift
        to_edge(140);
        brake_raw = 1'b1;
        to_edge(145);
        chk("brake_early", int'(brake), 0);
        to_edge(146);
        chk("brake_on", int'(brake), 1);
        to_edge(150); shift_up_raw = 1'b1;
        to_edge(160); shift_up_raw = 1'b0;
        to_edge(170);
        shift_down_raw = 1'b1;
        expect_pulse(170 + LAT, 1);
        to_edge(180); shift_down_raw = 1'b0;
        to_edge(190); brake_raw = 1'b0;
        to_edge(200);
        chk("brake_off", int'(brake), 0);

        // Simultaneous edges dropped; reset during holdoff with lever held
        to_edge(210);
        shift_up_raw   = 1'b1;
        shift_down_raw = 1'b1;
        to_edge(220);
        shift_up_raw   = 1'b0;
        shift_down_raw = 1'b0;
        to_edge(235);
        shift_up_raw = 1'b1;
        expect_pulse(235 + LAT, 0);
        to_edge(245);
        reset = 1'b1;
        win_hi[win_hi.size() - 1] = 245;
        to_edge(247);
        reset = 1'b0;
        expect_pulse(248 + DEB + 2, 0);
        to_edge(262);
        shift_up_raw = 1'b0;

`ifdef AUTO_REPEAT_EN
        to_edge(290);
        shift_down_raw = 1'b1;
        for (int k = 0; k < 4; k++) expect_pulse(290 + LAT + k * REP, 1);
        to_edge(360);
        shift_down_raw = 1'b0;
        to_edge(400);
`else
        to_edge(300);
`endif
        chk("pending_pulses", exp_edge_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_input_conditioner.md
Name: shift_input_conditioner

Overview:
- Front end that produces the `shift_up`, `shift_down` and `brake` command inputs consumed by `gearbox_fsm`. It is the producer side of that command interface.
- Takes raw, asynchronous push-button/pedal levels and synchronises and debounces them.
- Converts gear-lever presses into single-cycle, rate-limited shift pulses and passes a clean brake level through.
- Sits between the top-level GPIO inputs and the gearbox FSM, in the 25 kHz clock domain.

Parameters:
- DEBOUNCE_CYCLES, 250, consecutive cycles an input must differ from its debounced value before that value updates (10 ms at 25 kHz); must be >= 1.
- HOLDOFF_CYCLES, 1250, lockout after each issued shift pulse, during which new presses are discarded (50 ms); must be >= 1.
- REPEAT_CYCLES, 12500, auto-repeat interval (500 ms); used only when AUTO_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock, 25 kHz
- reset  input  1  synchronous, active-high reset
- shift_up_raw  input  1  raw up-lever level, asynchronous, active high
- shift_down_raw  input  1  raw down-lever level, asynchronous, active high
- brake_raw  input  1  raw brake level, asynchronous, active high
- shift_up  output  1  one-cycle up-shift command pulse to gearbox FSM
- shift_down  output  1  one-cycle down-shift command pulse to gearbox FSM
- brake  output  1  debounced brake level to gearbox FSM
- busy  output  1  high while a pulse or holdoff is in progress

Behaviour:
- Reset: all sync flops, debounced values, edge-history flops and counters go to 0. The FSM goes to IDLE. `shift_up`, `shift_down`, `brake` and `busy` are all 0 from the first edge with reset high.
- Synchroniser: each raw input passes through a 2-flop synchroniser (s1 <= raw; s2 <= s1).
- Debouncer: one per channel, counter width $clog2(DEBOUNCE_CYCLES+1).
  - If s2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and never reaches db.
- Brake output: `brake` = db_brake, as a register output.
- Edge detect: rise_up = db_up & ~db_up_d and rise_dn = db_dn & ~db_dn_d, with db_*_d registered each cycle. Falling edges are ignored.
- Latency: raw high first sampled at edge k -> `shift_up` (or `shift_down`) high from edge k+DEBOUNCE_CYCLES+2 for exactly one cycle.
- State IDLE:
  - rise_up & rise_dn in the same cycle -> both discarded, stay IDLE.
  - rise_up & db_brake -> discarded (no up-shift while braking), stay IDLE.
  - rise_up alone -> assert `shift_up` next cycle, go to PULSE.
  - rise_dn -> assert `shift_down` next cycle, go to PULSE. Brake does not block down-shifts.
- State PULSE: lasts exactly 1 cycle, in which exactly one of `shift_up`/`shift_down` is high. Loads the holdoff counter with 0, then goes to HOLDOFF.
- State HOLDOFF:
  - The counter increments each cycle; when it equals HOLDOFF_CYCLES-1, go to IDLE.
  - Rising edges that occur in HOLDOFF are dropped, not queued.
  - A lever still held on return to IDLE does not fire; it has no new edge.
- busy: 1 in PULSE and HOLDOFF, 0 in IDLE. busy is a registered decode of the next state, so it rises in the same cycle as the pulse.
- Reset mid-operation: state returns to IDLE and all counters clear. A raw input still held high after reset is seen as a fresh press and produces a pulse after the full latency.
- Holdoff counter width: $clog2(HOLDOFF_CYCLES+1).
- `shift_up` and `shift_down` are never high simultaneously.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- When defined: in IDLE (including on entry from HOLDOFF), if the same lever's db stays high, a repeat counter runs from the original pulse. Every REPEAT_CYCLES cycles it issues another pulse on the same output, via PULSE/HOLDOFF.
  - The brake rule still blocks up-repeats.
  - Releasing db, or db of the other lever going high, clears the repeat counter and issues no pulse.
- When undefined: one pulse per press exactly as above, and REPEAT_CYCLES is unused.

Test Plan:
- Run with DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8.
- Scenario 1: reset high 3 cycles, then raw up held from edge 10 -> `shift_up`=1 only in the cycle after edge 16, `busy` high for cycles 16..24, `shift_down`=0 throughout.
- Scenario 2: raw up pulses of 1, 2 and 3 cycles separated by gaps of 5 cycles -> no `shift_up` pulse and `busy` stays 0.
- Scenario 3: up press, then down press whose debounced edge lands 3 cycles after the up pulse -> only `shift_up` fires; a second down press after holdoff -> one `shift_down` pulse.
- Scenario 4: brake_raw held high, then up press, then down press -> `brake`=1 after 6 cycles, no `shift_up`, one `shift_down` pulse.
- Scenario 5: up and down raw rising on the same edge -> zero pulses. Assert reset during HOLDOFF with up still held -> `busy`=0 at the next edge, then a fresh `shift_up` 6 cycles after reset drops.
- Scenario 6 (AUTO_REPEAT_EN, REPEAT_CYCLES=20): hold down for 70 cycles -> `shift_down` pulses at t0, t0+20, t0+40 and t0+60.
